axi_brom_ctrl: RTL
==================

AXI_BROM_CTRL -- requirements
Module: axi_brom_ctrl

Interface
REQ-001 Parameters SHALL be ID_W (default 4, AXI ID width), ADDR_W (default 20, byte address width) and DATA_W (default 128, data width; fixed 16-byte beats).
REQ-002 Port clka SHALL be an input, 1 bit wide, and is the single clock; all logic is on its rising edge.
REQ-003 Port rsta SHALL be an input, 1 bit wide, and is the synchronous, active-high reset.
REQ-004 Ports s_axi_arid/araddr/arlen/arburst/arvalid SHALL be inputs of widths ID_W/ADDR_W/8/2/1, carrying the read request.
REQ-005 Port s_axi_arready SHALL be an output, 1 bit wide.
REQ-006 Ports s_axi_rid/rdata/rresp/rlast/rvalid SHALL be outputs of widths ID_W/DATA_W/2/1/1; s_axi_rready SHALL be a 1-bit input.
REQ-007 Ports s_axi_awid/awvalid, s_axi_wlast/wvalid and s_axi_bready SHALL be inputs of widths ID_W/1, 1/1 and 1; s_axi_wdata and s_axi_wstrb are accepted and ignored.
REQ-008 Ports s_axi_awready, s_axi_wready, s_axi_bid (ID_W), s_axi_bresp (2) and s_axi_bvalid SHALL be outputs.
REQ-009 Ports bram_addr (ADDR_W), bram_en (1), bram_we (DATA_W/8) and bram_din (DATA_W) SHALL be outputs; bram_dout (DATA_W) SHALL be an input.

Function
REQ-010 The block SHALL be an AXI4 read-only slave that drives the ROM port; bram_we and bram_din SHALL be tied to 0.
REQ-011 Read FSM states SHALL be R_IDLE and R_BURST; arready=1 only in R_IDLE; an AR handshake latches id/addr/len/burst and moves to R_BURST.
REQ-012 In R_BURST, bram_en=1 with bram_addr = current beat address (low 4 bits zero) SHALL be issued only when the read buffer has a free slot counting in-flight requests.
REQ-013 bram_dout SHALL be captured into the read buffer exactly 1 cycle after the bram_en cycle.
REQ-014 Address step: FIXED keeps the address; INCR adds 16; WRAP adds 16 and wraps within an aligned (len+1)*16-byte window, with len restricted to 1, 3, 7 or 15.
REQ-015 INCR addresses SHALL wrap modulo 2^ADDR_W.
REQ-016 WRAP with an illegal len and burst=2'b11 SHALL be treated as INCR, with rresp=SLVERR on every beat.
REQ-017 Beat count SHALL be len+1 (1..256); rlast=1 on the final beat only; the FSM returns to R_IDLE after the last issue, and the next AR may be accepted while buffered beats drain.
REQ-018 Read buffer SHALL be 2 entries of {data,id,resp,last}; rvalid = buffer non-empty; the head pops on rvalid&rready; with rready held high, throughput SHALL be 1 beat/cycle.
REQ-019 R outputs SHALL stay stable while rvalid=1 and rready=0.
REQ-020 Write FSM states SHALL be W_IDLE, W_DRAIN and W_RESP: awready=1 in W_IDLE; wready=1 in W_DRAIN; wvalid&wlast moves to W_RESP; there bvalid=1, bid = latched awid and bresp=2'b10 (SLVERR); bready returns to W_IDLE.
REQ-021 The read and write paths SHALL be independent and may be active concurrently.

Reset
REQ-022 While rsta=1, both FSMs SHALL go idle, the buffer empties and the in-flight flag clears.
REQ-023 During reset, outputs SHALL be: arready=0, awready=0, wready=0, rvalid=0, bvalid=0, bram_en=0, rlast=0, rresp=0, bresp=0 and bram_addr=0.
REQ-024 A burst interrupted by reset SHALL be abandoned, with no further R beats; arready=1 SHALL be asserted the first cycle after reset deasserts.

Structure
REQ-025 Shared package axi_brom_pkg SHALL hold the burst encodings (FIXED/INCR/WRAP), the resp encodings (OKAY/SLVERR), the beat-size constant 16 and the FSM state enums.
REQ-026 The 2-entry read buffer SHALL be the sub-module axi_brom_rbuf; everything else is in axi_brom_ctrl.

Verification
REQ-027 AR addr=0x00100, len=3, INCR, rready=1 -> bram_addr 0x100/0x110/0x120/0x130 on consecutive cycles; 4 R beats back-to-back, rlast on beat 4, rresp=0.
REQ-028 AR addr=0x00130, len=3, WRAP -> bram_addr 0x130/0x100/0x110/0x120.
REQ-029 INCR len=7 with rready toggling 1-0-0-1 -> no lost or duplicated beats, data stable while stalled, never more than 2 beats outstanding.
REQ-030 AW id=5 plus 4 W beats with wlast on beat 4 -> single B with bid=5 and bresp=2'b10 after beat 4; concurrent read burst unaffected.
REQ-031 rsta pulsed mid INCR len=15 burst -> rvalid=0 the next cycle, no further beats, arready=1 the first cycle after reset, and a new burst completes correctly.
REQ-032 AR with len=2 and WRAP -> 3 beats, rresp=SLVERR on each, INCR addressing.

Source files
------------

// File: rtl/axi_brom_pkg.sv
// Shared encodings, constants and FSM state types for the AXI block-ROM controller.
package axi_brom_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int BEAT_BYTES = 16;

    typedef enum logic {R_IDLE, R_BURST} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DRAIN, W_RESP} w_state_t;

    // Only power-of-two beat counts of 2..16 form a legal wrap window.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_brom_rbuf.sv
// Two-entry read-beat buffer; head is presented combinationally and pops on rd_en.
module axi_brom_rbuf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         valid,
    output logic [1:0]   count
);

    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic       push;
    logic       pop;

    assign pop  = rd_en && (count_reg != 2'd0);
    assign push = wr_en && (count_reg != 2'd2);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [W-1:0] data_reg;
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == 1'(gi))) begin
                    data_reg <= wr_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + 2'(push) - 2'(pop);
        end
    end

    assign rd_data = rd_ptr_reg ? g_entry[1].data_reg : g_entry[0].data_reg;
    assign valid   = (count_reg != 2'd0);
    assign count   = count_reg;

endmodule

// File: rtl/axi_brom_ctrl.sv
// AXI4 read-only slave in front of a block ROM with one-cycle read latency.
// Writes are drained and answered with SLVERR.
module axi_brom_ctrl
    import axi_brom_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 20,
    parameter int DATA_W = 128
) (
    input  logic                clka,
    input  logic                rsta,
    input  logic [ID_W-1:0]     s_axi_arid,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [ID_W-1:0]     s_axi_rid,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    input  logic [ID_W-1:0]     s_axi_awid,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [ID_W-1:0]     s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    output logic [ADDR_W-1:0]   bram_addr,
    output logic                bram_en,
    output logic [DATA_W/8-1:0] bram_we,
    output logic [DATA_W-1:0]   bram_din,
    input  logic [DATA_W-1:0]   bram_dout
);

    localparam int PAY_W = DATA_W + ID_W + 3;

    r_state_t          r_state_reg, r_state_next;
    w_state_t          w_state_reg, w_state_next;
    logic [ID_W-1:0]   ar_id_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [7:0]        beats_left_reg;
    logic [3:0]        len_lo_reg;
    logic [1:0]        burst_reg;
    logic [1:0]        resp_reg;
    logic              inflight_reg;
    logic [ID_W-1:0]   inflight_id_reg;
    logic [1:0]        inflight_resp_reg;
    logic              inflight_last_reg;
    logic [ID_W-1:0]   bid_reg;

    logic              ar_hs, issue, pop, can_issue, ar_bad;
    logic [2:0]        occupancy;
    logic [1:0]        buf_count;
    logic              buf_valid;
    logic [PAY_W-1:0]  buf_rd_data;
    logic [ADDR_W-1:0] addr_incr, wrap_mask, addr_next;
    logic [ID_W-1:0]   head_id;
    logic [1:0]        head_resp;
    logic              head_last;

    wire unused_inputs = ^{s_axi_wdata, s_axi_wstrb, s_axi_araddr[3:0]};

    assign bram_we  = '0;
    assign bram_din = '0;

    // ---------------- read FSM ----------------
    assign pop       = buf_valid && s_axi_rready && !rsta;
    assign occupancy = 3'(buf_count) + 3'(inflight_reg);
    // A slot is free if what is buffered plus in flight, less this cycle's pop, leaves room.
    assign can_issue = pop ? (occupancy <= 3'd2) : (occupancy <= 3'd1);
    assign ar_hs     = s_axi_arready && s_axi_arvalid;
    assign ar_bad    = (s_axi_arburst == 2'b11) ||
                       ((s_axi_arburst == BURST_WRAP) && !wrap_len_ok(s_axi_arlen));

    always_ff @(posedge clka) begin
        if (rsta) r_state_reg <= R_IDLE;
        else      r_state_reg <= r_state_next;
    end

    always_comb begin
        r_state_next = r_state_reg;
        case (r_state_reg)
            R_IDLE:  if (ar_hs) r_state_next = R_BURST;
            R_BURST: if (issue && (beats_left_reg == 8'd0)) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        s_axi_arready = 1'b0;
        issue         = 1'b0;
        if (!rsta) begin
            s_axi_arready = (r_state_reg == R_IDLE);
            issue         = (r_state_reg == R_BURST) && can_issue;
        end
    end

    assign bram_en   = issue;
    assign bram_addr = issue ? addr_reg : '0;

    assign addr_incr = addr_reg + ADDR_W'(BEAT_BYTES);
    assign wrap_mask = ADDR_W'({len_lo_reg, 4'hF});
    always_comb begin
        case (burst_reg)
            BURST_FIXED: addr_next = addr_reg;
            BURST_WRAP:  addr_next = (addr_reg & ~wrap_mask) | (addr_incr & wrap_mask);
            default:     addr_next = addr_incr;
        endcase
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            ar_id_reg         <= '0;
            addr_reg          <= '0;
            beats_left_reg    <= '0;
            len_lo_reg        <= '0;
            burst_reg         <= BURST_INCR;
            resp_reg          <= RESP_OKAY;
            inflight_reg      <= 1'b0;
            inflight_id_reg   <= '0;
            inflight_resp_reg <= RESP_OKAY;
            inflight_last_reg <= 1'b0;
        end else begin
            if (ar_hs) begin
                ar_id_reg      <= s_axi_arid;
                addr_reg       <= {s_axi_araddr[ADDR_W-1:4], 4'b0000};
                beats_left_reg <= s_axi_arlen;
                len_lo_reg     <= s_axi_arlen[3:0];
                burst_reg      <= ar_bad ? BURST_INCR : s_axi_arburst;
                resp_reg       <= ar_bad ? RESP_SLVERR : RESP_OKAY;
            end else if (issue) begin
                addr_reg       <= addr_next;
                beats_left_reg <= beats_left_reg - 8'd1;
            end
            inflight_reg <= issue;
            if (issue) begin
                inflight_id_reg   <= ar_id_reg;
                inflight_resp_reg <= resp_reg;
                inflight_last_reg <= (beats_left_reg == 8'd0);
            end
        end
    end

    axi_brom_rbuf #(.W(PAY_W)) u_rbuf (
        .clk     (clka),
        .srst    (rsta),
        .wr_en   (inflight_reg),
        .wr_data ({bram_dout, inflight_id_reg, inflight_resp_reg, inflight_last_reg}),
        .rd_en   (pop),
        .rd_data (buf_rd_data),
        .valid   (buf_valid),
        .count   (buf_count)
    );

    assign {s_axi_rdata, head_id, head_resp, head_last} = buf_rd_data;
    assign s_axi_rid    = head_id;
    assign s_axi_rvalid = buf_valid && !rsta;
    assign s_axi_rresp  = s_axi_rvalid ? head_resp : RESP_OKAY;
    assign s_axi_rlast  = s_axi_rvalid && head_last;

    // ---------------- write FSM ----------------
    always_ff @(posedge clka) begin
        if (rsta) begin
            w_state_reg <= W_IDLE;
            bid_reg     <= '0;
        end else begin
            w_state_reg <= w_state_next;
            if (s_axi_awready && s_axi_awvalid) bid_reg <= s_axi_awid;
        end
    end

    always_comb begin
        w_state_next = w_state_reg;
        case (w_state_reg)
            W_IDLE:  if (s_axi_awvalid) w_state_next = W_DRAIN;
            W_DRAIN: if (s_axi_wvalid && s_axi_wlast) w_state_next = W_RESP;
            W_RESP:  if (s_axi_bready) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_bresp   = RESP_OKAY;
        if (!rsta) begin
            s_axi_awready = (w_state_reg == W_IDLE);
            s_axi_wready  = (w_state_reg == W_DRAIN);
            s_axi_bvalid  = (w_state_reg == W_RESP);
            if (w_state_reg == W_RESP) s_axi_bresp = RESP_SLVERR;
        end
    end

    assign s_axi_bid = bid_reg;

endmodule
